// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_t;

  // Access size in bytes; illegal encodings report 4 but are rejected elsewhere.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_bytes = 3'd1;
      F3_H, F3_HU: size_bytes = 3'd2;
      default:     size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian byte/halfword lane handling: extracts and extends load data,
// and merges sub-word store data into a full word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  // Byte at offset k sits at bit 8*(3-k); halfword at offset 0 sits at bit 16.
  logic [4:0] byte_sh;
  logic [4:0] half_sh;
  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  assign byte_sh   = {~offset, 3'b000};
  assign half_sh   = {~offset[1], 4'b0000};
  assign byte_lane = word[byte_sh +: 8];
  assign half_lane = word[half_sh +: 16];
  assign byte_mask = 32'h0000_00FF << byte_sh;
  assign half_mask = 32'h0000_FFFF << half_sh;

  always_comb begin
    rdata = 32'd0;
    case (funct3)
      F3_B:    rdata = 32'(byte_lane);
      F3_H:    rdata = 32'(half_lane);
      F3_W:    rdata = word;
      F3_BU:   rdata = {24'd0, byte_lane};
      F3_HU:   rdata = {16'd0, half_lane};
      default: rdata = 32'd0;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B:    merged = (word & ~byte_mask) | ({24'd0, wdata[7:0]} << byte_sh);
      F3_H:    merged = (word & ~half_mask) | ({16'd0, wdata} << half_sh);
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: one request at a time, alignment and
// range checking, word-wide memory port with read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  lsu_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;

  logic              accept;
  logic              f3_ok;
  logic              misaligned;
  logic              out_of_range;
  logic              req_bad;
  logic [ADDR_W:0]   end_addr;

  logic [31:0]       align_word;
  logic [31:0]       ext_rdata;
  logic [31:0]       merged_word;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign accept     = req_valid && req_ready;

  // End address is one bit wider than the bus so a huge address cannot wrap into range.
  assign end_addr = {1'b0, req_addr} + {{(ADDR_W-2){1'b0}}, size_bytes(req_funct3)};

  always_comb begin
    if (req_write) f3_ok = req_funct3 inside {F3_B, F3_H, F3_W};
    else           f3_ok = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    misaligned = 1'b0;
    if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) misaligned = 1'b1;
    if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)               misaligned = 1'b1;
    out_of_range = (end_addr > MEM_LIMIT);
    req_bad      = !f3_ok || misaligned || out_of_range;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_bad)                 state_d = ST_RESP;
          else if (!req_write)         state_d = ST_LOAD;
          else if (req_funct3 == F3_W) state_d = ST_WRITE;
          else                         state_d = ST_RMW_RD;
        end
      end
      ST_LOAD, ST_WRITE, ST_RMW_WR: state_d = ST_RESP;
      ST_RMW_RD:                    state_d = ST_RMW_WR;
      ST_RESP:                      state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Request capture: datapath only, held stable until the response completes.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= req_addr;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      merge_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            resp_err   <= req_bad;
            resp_rdata <= 32'd0;
          end
        end
        ST_LOAD:   resp_rdata <= ext_rdata;
        ST_RMW_RD: merge_q    <= mem_rdata;
        ST_RESP: begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The lane aligner sees live memory data during a load, the captured word otherwise.
  assign align_word = (state_q == ST_LOAD) ? mem_rdata : merge_q;

  lsu_lane_align u_lane_align (
    .word   (align_word),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .wdata  (wdata_q[15:0]),
    .rdata  (ext_rdata),
    .merged (merged_word)
  );

  always_comb begin
    mem_read     = 1'b0;
    mem_write_en = 1'b0;
    mem_wdata    = 32'd0;
    case (state_q)
      ST_LOAD, ST_RMW_RD: mem_read = 1'b1;
      ST_WRITE: begin
        mem_write_en = 1'b1;
        mem_wdata    = wdata_q;
      end
      ST_RMW_WR: begin
        mem_write_en = 1'b1;
        mem_wdata    = merged_word;
      end
      default: ;
    endcase
  end

  assign mem_addr = (mem_read || mem_write_en) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word-ported memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_write_en;
  logic              mem_read;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int viol   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(1024), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_write_en) mem[mem_addr[9:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_write_en) wr_cnt++;
    if (mem_read) rd_cnt++;
    if (mem_read && mem_write_en) viol++;
    if (!mem_read && !mem_write_en && (mem_addr != '0 || mem_wdata != 32'd0)) viol++;
  end

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[7:0]; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic er, output int wrs, output int rds,
                        output logic post_v, output logic [31:0] post_rd, output logic post_er);
    int w0, r0;
    @(negedge clk);
    w0 = wr_cnt; r0 = rd_cnt;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    @(posedge clk); #1;
    post_v = resp_valid; post_rd = resp_rdata; post_er = resp_err;
    wrs = wr_cnt - w0; rds = rd_cnt - r0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", resp_err); end
    checks++; if ({mem_read, mem_write_en} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {mem_read, mem_write_en}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lw();
    int lat, wrs, rds; logic [31:0] rd, prd; logic er, pv, per;
    preload(1, 32'h0000000C);
    do_req(1'b0, F3_W, 32'h4, 32'h0, lat, rd, er, wrs, rds, pv, prd, per);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'h0000000C) begin errors++; $display("FAIL lw_rdata got %h want 0000000c", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %0b want 0", er); end
    checks++; if (rds !== 1 || wrs !== 0) begin errors++; $display("FAIL lw_strobes got rd=%0d wr=%0d want 1/0", rds, wrs); end
    checks++; if (pv !== 1'b0 || prd !== 32'd0) begin errors++; $display("FAIL lw_after_resp got v=%0b rdata=%h want 0/0", pv, prd); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [9]  = '{F3_B, F3_BU, F3_H, F3_HU, F3_B, F3_BU, F3_W, F3_H, F3_HU};
    logic [31:0] adrs [9] = '{32'h8, 32'h8, 32'hA, 32'h8, 32'h9, 32'hB, 32'h8, 32'h8, 32'hA};
    logic [31:0] exps [9] = '{32'hFFFFFF80, 32'h00000080, 32'h00003456, 32'h00008012,
                              32'h00000012, 32'h00000056, 32'h80123456, 32'hFFFF8012, 32'h00003456};
    int lat, wrs, rds; logic [31:0] rd, prd; logic er, pv, per;
    preload(2, 32'h80123456);
    for (int i = 0; i < 9; i++) begin
      do_req(1'b0, f3s[i], adrs[i], 32'h0, lat, rd, er, wrs, rds, pv, prd, per);
      checks++;
      if (rd !== exps[i] || er !== 1'b0 || lat !== 2) begin
        errors++;
        $display("FAIL load_ext[%0d] got rdata=%h err=%0b lat=%0d want %h/0/2", i, rd, er, lat, exps[i]);
      end
    end
  endtask

  task automatic test_sub_store();
    int lat, wrs, rds; logic [31:0] rd, prd; logic er, pv, per;
    preload(1, 32'h0000000C);
    do_req(1'b1, F3_B, 32'h5, 32'h000000AB, lat, rd, er, wrs, rds, pv, prd, per);
    checks++; if (mem[1] !== 32'h00AB000C) begin errors++; $display("FAIL sb_word got %h want 00ab000c", mem[1]); end
    checks++; if (lat !== 3 || wrs !== 1 || rds !== 1) begin errors++; $display("FAIL sb_timing got lat=%0d wr=%0d rd=%0d want 3/1/1", lat, wrs, rds); end
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL sb_resp got rdata=%h err=%0b want 0/0", rd, er); end
    do_req(1'b1, F3_H, 32'h6, 32'h00001234, lat, rd, er, wrs, rds, pv, prd, per);
    checks++; if (mem[1] !== 32'h00AB1234) begin errors++; $display("FAIL sh_word got %h want 00ab1234", mem[1]); end
    checks++; if (lat !== 3 || wrs !== 1 || rds !== 1) begin errors++; $display("FAIL sh_timing got lat=%0d wr=%0d rd=%0d want 3/1/1", lat, wrs, rds); end
  endtask

  task automatic test_sw();
    int lat, wrs, rds; logic [31:0] rd, prd; logic er, pv, per;
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, rd, er, wrs, rds, pv, prd, per);
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_word got %h want deadbeef", mem[4]); end
    checks++; if (lat !== 2 || wrs !== 1 || rds !== 0) begin errors++; $display("FAIL sw_timing got lat=%0d wr=%0d rd=%0d want 2/1/0", lat, wrs, rds); end
    do_req(1'b1, F3_W, 32'h3FC, 32'hCAFEF00D, lat, rd, er, wrs, rds, pv, prd, per);
    checks++; if (er !== 1'b0 || mem[255] !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_last_word got err=%0b word=%h want 0/cafef00d", er, mem[255]); end
    do_req(1'b0, F3_W, 32'h3FC, 32'h0, lat, rd, er, wrs, rds, pv, prd, per);
    checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL lw_last_word got %h err=%0b want cafef00d/0", rd, er); end
  endtask

  task automatic test_errors();
    logic        ws   [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s  [9] = '{F3_H, F3_W, F3_W, F3_B, 3'b011, F3_BU, F3_HU, F3_B, F3_B};
    logic [31:0] adrs [9] = '{32'h3, 32'h2, 32'h3FE, 32'h400, 32'h0, 32'h0, 32'h400, 32'hFFFFFFFF, 32'h400};
    int lat, wrs, rds; logic [31:0] rd, prd; logic er, pv, per;
    preload(0, 32'h11223344);
    for (int i = 0; i < 9; i++) begin
      do_req(ws[i], f3s[i], adrs[i], 32'hFFFFFFFF, lat, rd, er, wrs, rds, pv, prd, per);
      checks++;
      if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || wrs !== 0 || rds !== 0 || per !== 1'b0) begin
        errors++;
        $display("FAIL err[%0d] got err=%0b rdata=%h lat=%0d wr=%0d rd=%0d post_err=%0b want 1/0/1/0/0/0",
                 i, er, rd, lat, wrs, rds, per);
      end
    end
    checks++; if (mem[0] !== 32'h11223344) begin errors++; $display("FAIL err_mem_untouched got %h want 11223344", mem[0]); end
  endtask

  task automatic test_back_to_back();
    preload(1, 32'h0000000C);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h4;
    @(posedge clk); #1;
    req_addr = 32'h8;
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_load_cycle got ready=%0b valid=%0b want 0/0", req_ready, resp_valid); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'h0000000C) begin
      errors++; $display("FAIL b2b_first_resp got ready=%0b valid=%0b rdata=%h want 0/1/0000000c", req_ready, resp_valid, resp_rdata); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
      errors++; $display("FAIL b2b_idle got ready=%0b valid=%0b rdata=%h want 1/0/0", req_ready, resp_valid, resp_rdata); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || mem_read !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got ready=%0b read=%0b want 0/1", req_ready, mem_read); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h80123456) begin
      errors++; $display("FAIL b2b_second_resp got valid=%0b rdata=%h want 1/80123456", resp_valid, resp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_rmw();
    preload(1, 32'h0000000C);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_B; req_addr = 32'h4; req_wdata = 32'h000000FF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_write_en !== 1'b1 || mem_wdata !== 32'hFF00000C) begin
      errors++; $display("FAIL rmw_wr_cycle got we=%0b wdata=%h want 1/ff00000c", mem_write_en, mem_wdata); end
    rst = 1'b1;
    #1;
    checks++; if ({mem_read, mem_write_en} !== 2'b00 || mem_addr !== '0 || mem_wdata !== 32'd0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_outputs got rd=%0b we=%0b addr=%h wdata=%h valid=%0b want all 0",
                         mem_read, mem_write_en, mem_addr, mem_wdata, resp_valid); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem[1] !== 32'h0000000C) begin errors++; $display("FAIL rst_no_commit got %h want 0000000c", mem[1]); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b want 1", req_ready); end
  endtask

  task automatic test_strobe_rules();
    checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_rules got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_sub_store();
    test_sw();
    test_errors();
    test_back_to_back();
    test_reset_rmw();
    test_strobe_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage controller that sits directly upstream of the byte-addressed, word-ported data memory.
- Accepts one RV32I load/store request at a time from the execute stage and checks alignment and range.
- Drives the memory's word-wide read/write port, using read-modify-write for SB/SH.
- Returns sign- or zero-extended load data to writeback.

Parameters:
- MEM_BYTES, 1024, size of the data memory in bytes; any access with addr+size > MEM_BYTES is an error.
- ADDR_W, 32, request/memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3.
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_write_en  out  1  write strobe; memory commits on the rising edge of clk.
- mem_read  out  1  read enable.
- mem_rdata  in  32  asynchronous read data, valid in the same cycle as mem_read.

Behaviour:
- Byte order is big-endian within a word. The byte at offset k occupies bits [31-8k -: 8]. A halfword at offset 0 is bits 31:16; at offset 2 it is bits 15:0.
- States:
  - IDLE
  - LOAD: mem_read=1; the extended result is captured at the clock edge.
  - WRITE: mem_write_en=1, mem_wdata=req_wdata.
  - RMW_RD: mem_read=1; the word is captured into merge_q.
  - RMW_WR: mem_write_en=1; mem_wdata = merge_q with the target lane replaced.
  - RESP: resp_valid=1.
- Request acceptance:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - addr, funct3, write and wdata are registered on acceptance and stay stable until RESP ends.
- Next state after IDLE:
  - Error → RESP with resp_err=1 and no memory access.
  - Load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_RD → RMW_WR.
  - LOAD, WRITE and RMW_WR all go to RESP; RESP goes to IDLE.
- Latency, in edges after acceptance until resp_valid is high:
  - Loads: 2.
  - SW: 2.
  - SB/SH: 3.
  - Errors: 1.
- Memory outputs:
  - mem_read and mem_write_en are decoded from the state register only. Both are 0 in IDLE and RESP, and they are never high together.
  - mem_addr and mem_wdata are 0 whenever both strobes are low.
- Error conditions:
  - funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr+size > MEM_BYTES (unsigned, computed at ADDR_W+1 bits, so no wrap-around).
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- resp_rdata and resp_err are registered. They hold their value from the completion edge through the RESP cycle and return to 0 on the edge leaving RESP.
- req_valid arriving during a busy state is ignored (req_ready=0); the requester holds it.
- Reset (asynchronous): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, merge_q=0. All mem_* outputs drop to 0 immediately.
  - Reset asserted during RMW_WR or WRITE prevents that cycle's commit, so memory is left unchanged.
  - A captured but unreturned load is discarded.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t.
  - Size function (1/2/4 bytes).
- One sub-module, lsu_lane_align (combinational):
  - Extract + extend: word, offset, funct3 → rdata.
  - Merge: word, offset, funct3, wdata → merged word.
  - The FSM top instantiates it once.

Test Plan:
- Memory word at 0x4 = 0x0000000C. LW 0x4 → resp_rdata 0x0000000C, resp_err 0, resp_valid exactly 2 edges after acceptance.
- Memory bytes 0x8..0xB = 80 12 34 56:
  - LB 0x8 → 0xFFFFFF80.
  - LBU 0x8 → 0x00000080.
  - LH 0xA → 0x00003456.
  - LHU 0x8 → 0x00008012.
- Memory word at 0x4 = 0x0000000C:
  - SB 0x5 with wdata 0x000000AB → word becomes 0x00AB000C.
  - SH 0x6 with wdata 0x00001234 → 0x00AB1234.
  - Each completes in 3 edges, with one mem_write_en cycle.
- SH 0x3 or LW 0x2 or LW 0x3FE (MEM_BYTES=1024) → resp_err 1 and resp_rdata 0, resp_valid after 1 edge, mem_read/mem_write_en never asserted.
- Assert rst during the RMW_WR cycle of SB 0x4 → no write (word still 0x0000000C), outputs 0 immediately, req_ready 1 after release.
- Back-to-back: req_valid held high with two requests → second accepted only on the edge following RESP; req_ready low throughout busy states.
